// File: rtl/kbd_scancode_decoder.sv
// PS/2 set-2 scan byte decoder: prefix collapse, modifiers, ASCII, event FIFO.
// Define KBD_TYPEMATIC_FILTER_EN to drop typematic repeat makes of held keys.
module kbd_scancode_decoder #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] kb_data,
  input  logic       kb_ready,
  output logic       kb_nextdata_n,
  output logic       ev_valid,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic [7:0] ev_ascii,
  input  logic       ev_rd,
  output logic       shift,
  output logic       ctrl,
  output logic       caps,
  input  logic       ovf_clr,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ACK, GAP} st_t;

  st_t        st, st_nx;
  logic [7:0] lat;
  logic       ext_pend, brk_pend;
  logic       d_vld, d_ext, d_brk;
  logic [7:0] d_code;
  logic       lsh, rsh, lct, rct, caps_held;

  logic       is_brk, is_ext, is_disc;
  logic       rep, ev_take, push, pop, full, empty;
  logic [7:0] ascii;
  logic [17:0] ent, head;

  logic [17:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;

`ifdef KBD_TYPEMATIC_FILTER_EN
  logic [511:0] held;
`endif

  function automatic logic [7:0] to_ascii(
    input logic [7:0] c,
    input logic       up,
    input logic       sh
  );
    logic [7:0] l, d, s;
    l = 8'h00;
    d = 8'h00;
    s = 8'h00;
    case (c)
      8'h1c: l = "a";
      8'h32: l = "b";
      8'h21: l = "c";
      8'h23: l = "d";
      8'h24: l = "e";
      8'h2b: l = "f";
      8'h34: l = "g";
      8'h33: l = "h";
      8'h43: l = "i";
      8'h3b: l = "j";
      8'h42: l = "k";
      8'h4b: l = "l";
      8'h3a: l = "m";
      8'h31: l = "n";
      8'h44: l = "o";
      8'h4d: l = "p";
      8'h15: l = "q";
      8'h2d: l = "r";
      8'h1b: l = "s";
      8'h2c: l = "t";
      8'h3c: l = "u";
      8'h2a: l = "v";
      8'h1d: l = "w";
      8'h22: l = "x";
      8'h35: l = "y";
      8'h1a: l = "z";
      8'h16: begin d = "1"; s = "!"; end
      8'h1e: begin d = "2"; s = "@"; end
      8'h26: begin d = "3"; s = "#"; end
      8'h25: begin d = "4"; s = "$"; end
      8'h2e: begin d = "5"; s = "%"; end
      8'h36: begin d = "6"; s = "^"; end
      8'h3d: begin d = "7"; s = "&"; end
      8'h3e: begin d = "8"; s = "*"; end
      8'h46: begin d = "9"; s = "("; end
      8'h45: begin d = "0"; s = ")"; end
      default: ;
    endcase
    if (l != 8'h00) return up ? (l - 8'h20) : l;
    if (d != 8'h00) return sh ? s : d;
    case (c)
      8'h29:   return 8'h20;
      8'h5a:   return 8'h0d;
      8'h66:   return 8'h08;
      default: return 8'h00;
    endcase
  endfunction

  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE:    if (kb_ready) st_nx = ACK;
      ACK:     st_nx = GAP;
      GAP:     st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  assign is_brk  = (lat == 8'hf0);
  assign is_ext  = (lat == 8'he0) || (lat == 8'he1);
  assign is_disc = (lat == 8'h00) || (lat == 8'haa) ||
                   (lat == 8'hee) || (lat == 8'hfa) ||
                   (lat == 8'hfe) || (lat == 8'hff);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st            <= IDLE;
      kb_nextdata_n <= 1'b1;
      lat           <= '0;
      ext_pend      <= 1'b0;
      brk_pend      <= 1'b0;
      d_vld         <= 1'b0;
      d_ext         <= 1'b0;
      d_brk         <= 1'b0;
      d_code        <= '0;
    end else begin
      st            <= st_nx;
      kb_nextdata_n <= (st_nx != ACK);
      if (st == IDLE && kb_ready) lat <= kb_data;
      if (st == ACK) begin
        d_vld  <= !is_brk && !is_ext && !is_disc;
        d_ext  <= ext_pend;
        d_brk  <= brk_pend;
        d_code <= lat;
        unique case (1'b1)
          is_brk:  brk_pend <= 1'b1;
          is_ext:  ext_pend <= 1'b1;
          default: begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
          end
        endcase
      end
    end
  end

  // Decoded event lands in GAP, so ASCII sees modifiers from prior events.
`ifdef KBD_TYPEMATIC_FILTER_EN
  assign rep = !d_brk && held[{d_ext, d_code}];
`else
  assign rep = 1'b0;
`endif

  assign ev_take = (st == GAP) && d_vld && !rep;
  assign ascii   = (d_ext || d_brk) ? 8'h00 :
                   to_ascii(d_code, shift ^ caps, shift);
  assign ent     = {d_ext, d_brk, ascii, d_code};

  assign shift = lsh | rsh;
  assign ctrl  = lct | rct;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lsh       <= 1'b0;
      rsh       <= 1'b0;
      lct       <= 1'b0;
      rct       <= 1'b0;
      caps      <= 1'b0;
      caps_held <= 1'b0;
`ifdef KBD_TYPEMATIC_FILTER_EN
      held      <= '0;
`endif
    end else if (ev_take) begin
      if (!d_ext && d_code == 8'h12) lsh <= !d_brk;
      if (!d_ext && d_code == 8'h59) rsh <= !d_brk;
      if (!d_ext && d_code == 8'h14) lct <= !d_brk;
      if (d_ext && d_code == 8'h14) rct <= !d_brk;
      if (!d_ext && d_code == 8'h58) begin
        if (!d_brk && !caps_held) caps <= ~caps;
        caps_held <= !d_brk;
      end
`ifdef KBD_TYPEMATIC_FILTER_EN
      held[{d_ext, d_code}] <= !d_brk;
`endif
    end
  end

  assign empty = (cnt == '0);
  assign full  = (cnt == FULL_CNT);
  assign pop   = ev_rd && !empty;
  assign push  = ev_take && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= ent;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp       <= '0;
      rp       <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
      if (ev_take && full && !pop) overflow <= 1'b1;
      else if (ovf_clr)            overflow <= 1'b0;
    end
  end

  assign head     = mem[rp];
  assign ev_valid = !empty;
  assign {ev_ext, ev_break, ev_ascii, ev_code} = ev_valid ? head : 18'h0;

endmodule

// File: doc/kbd_scancode_decoder.md
# kbd_scancode_decoder

Consumes raw PS/2 set-2 scan bytes from the keyboard receiver's ready/nextdata_n handshake, collapses 0xE0/0xF0 prefix sequences into single key events, tracks modifier state and translates make codes to ASCII. Events are queued in a show-ahead FIFO read by the CPU-side I/O register block. It sits directly downstream of the PS/2 receiver.

## Interface
- FIFO_DEPTH, 8: event FIFO entries; power of two, 2..64.
- clk  in  1  system clock; one clock.
- rst  in  1  reset; asynchronous, active-high.
- kb_data  in  8  scan byte from receiver, valid while kb_ready=1.
- kb_ready  in  1  receiver has a byte.
- kb_nextdata_n  out  1  active-low pop strobe to receiver, one cycle per byte.
- ev_valid  out  1  FIFO non-empty.
- ev_code  out  8  head event scan code (prefixes stripped).
- ev_ext  out  1  head event carried 0xE0/0xE1 prefix.
- ev_break  out  1  head event is key release.
- ev_ascii  out  8  head event ASCII, 0x00 if none.
- ev_rd  in  1  pop head event.
- shift, ctrl, caps  out  1 each  live modifier state.
- ovf_clr  in  1  clear overflow.
- overflow  out  1  sticky: event dropped because FIFO full.

## Operation
- Handshake FSM, states IDLE, ACK, GAP:
  - IDLE: if kb_ready=1, latch kb_data, go ACK; else stay.
  - ACK: kb_nextdata_n=0 (registered output); decode latched byte; go GAP.
  - GAP: kb_nextdata_n=1; go IDLE (lets receiver update ready/data).
- Decode of latched byte (in ACK):
  - 0xF0: set break_pend, no event. 0xE0/0xE1: set ext_pend, no event.
  - 0x00, 0xAA, 0xEE, 0xFA, 0xFE, 0xFF: discard, clear both prefixes, no event.
  - Other: event {ext_pend, break_pend, byte}; clear both prefixes.
- Modifiers, updated by events: shift = L(0x12) or R(0x59) held; ctrl = 0x14 held (ext or not); caps toggles on make of 0x58 only if 0x58 not already held.
- ASCII (non-ext make only; break/ext give 0x00): letters a–z, uppercase when shift XOR caps; digits 0–9, shifted to US symbols !@#$%^&*(); space 0x29→0x20; enter 0x5A→0x0D; backspace 0x66→0x08; all others 0x00. Ctrl does not alter ASCII.
- FIFO: 18-bit entries {ext, break, ascii, code}. ev_* show head combinationally; all ev_* fields 0 when ev_valid=0. ev_rd with ev_valid=0 ignored.
- Full: push without simultaneous pop drops event, sets overflow. Push and pop same cycle when full: both happen, no overflow. Pop and push when empty: push only.
- overflow cleared by ovf_clr; set wins if both same cycle.

## Timing
- Reset values: kb_nextdata_n=1, ev_valid=0, ev_* =0, shift=ctrl=caps=0, overflow=0, FSM IDLE, prefixes clear, FIFO empty. Reset mid-ACK releases kb_nextdata_n immediately (async).
- kb_ready seen high at edge N → kb_nextdata_n low for cycle N..N+1 exactly one cycle → event pushed and modifiers updated at edge N+2 → ev_valid high from N+2 (if empty) → next byte sampled no earlier than edge N+3.
- Throughput: one byte per 3 cycles.
- Pointers wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.

## Configuration
- KBD_TYPEMATIC_FILTER_EN defined: a make event whose {ext, code} is already held (make seen, no break since) is not enqueued; modifiers unaffected. Held-key set tracked per code (256×2 bits). Not defined: every typematic repeat make is enqueued.

## Test plan
- Bytes 0x1C, F0 1C → events {code 1C, make, ascii 0x61}, {1C, break, 0x00}; kb_nextdata_n one low cycle per byte.
- 0x12, 0x1C, F0 12, 0x1C → shift=1 then 0; ascii 0x41 then 0x61; caps via 0x58, F0 58, 0x58 → caps=1 after one press, repeat make while held does not toggle.
- E0 F0 75 → one event {75, ext=1, break=1, ascii 0}; 0xAA alone → no event.
- FIFO_DEPTH=8, 9 makes without ev_rd → 8 queued, overflow=1; ev_rd and push same cycle when full → no new overflow; ovf_clr → 0.
- rst asserted during ACK → kb_nextdata_n=1 same cycle, FIFO empty, pending F0 forgotten (next 0x1C is make).
- Macro defined: 0x1C ×3 then F0 1C → 2 events (make, break); undefined → 4.
